// File: rtl/seletor_voltas.sv
// Lap-time selector: debounces lap/review buttons, stores laps while counting,
// and chooses between live, frozen-lap and lap-recall values for the display.
module seletor_voltas #(
    parameter int MAX_VOLTAS    = 4,
    parameter int DEBOUNCE      = 500000,
    parameter int TEMPO_CONGELA = 100000000,
    parameter int INICIO        = 0,
    parameter int CONTAR        = 1,
    parameter int PAUSAR        = 2,
    parameter int PARAR         = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          volta,
    input  logic                          revisar,
    input  logic [2:0]                    estado,
    input  logic [3:0]                    cont_dec,
    input  logic [9:0]                    cont_seg,
    output logic [3:0]                    dec_disp,
    output logic [9:0]                    seg_disp,
    output logic [1:0]                    modo,
    output logic [$clog2(MAX_VOLTAS)-1:0] indice,
    output logic [$clog2(MAX_VOLTAS):0]   num_voltas,
    output logic                          cheio
);

    localparam int IW = $clog2(MAX_VOLTAS);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int TW = $clog2(TEMPO_CONGELA + 1);
    localparam logic [CW-1:0] DB_ULTIMO = CW'(DEBOUNCE - 1);
    localparam logic [TW-1:0] T_CARGA   = TW'(TEMPO_CONGELA);
    localparam logic [TW-1:0] T_UM      = TW'(1);
    localparam logic [IW:0]   N_MAX     = (IW+1)'(MAX_VOLTAS);

    typedef enum logic [1:0] {
        AO_VIVO   = 2'd0,
        CONGELADO = 2'd1,
        REVISAO   = 2'd2
    } modo_t;

    // Bit 0 = lap button, bit 1 = review button
    logic [1:0]    w_bruto;
    logic [1:0]    r_sinc1;
    logic [1:0]    r_sinc2;
    logic [1:0]    r_nivel;
    logic [1:0]    r_nivel_d;
    logic [CW-1:0] r_db_cnt [2];
    logic [1:0]    w_pulso;
    logic          w_p_volta;
    logic          w_p_revisar;

    assign w_bruto = {revisar, volta};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sinc1   <= '0;
            r_sinc2   <= '0;
            r_nivel   <= '0;
            r_nivel_d <= '0;
            for (int b = 0; b < 2; b++) begin
                r_db_cnt[b] <= '0;
            end
        end else begin
            r_sinc1   <= w_bruto;
            r_sinc2   <= r_sinc1;
            r_nivel_d <= r_nivel;
            // Level is accepted on the DEBOUNCE-th consecutive differing cycle
            for (int b = 0; b < 2; b++) begin
                if (r_sinc2[b] == r_nivel[b]) begin
                    r_db_cnt[b] <= '0;
                end else if (r_db_cnt[b] == DB_ULTIMO) begin
                    r_db_cnt[b] <= '0;
                    r_nivel[b]  <= r_sinc2[b];
                end else begin
                    r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
                end
            end
        end
    end

    assign w_pulso     = r_nivel & ~r_nivel_d;
    assign w_p_volta   = w_pulso[0];
    assign w_p_revisar = w_pulso[1];

    modo_t         r_modo;
    modo_t         w_modo_n;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_n;
    logic [IW-1:0] r_indice;
    logic [IW-1:0] w_indice_n;
    logic [IW:0]   r_num;
    logic [IW:0]   w_num_n;
    logic [IW:0]   w_ultimo;
    logic          w_cheio;
    logic          w_inicio;
    logic          w_contar;
    logic          w_parado;
    logic          w_grava;
    logic          w_rev_ok;

    assign w_cheio  = (r_num == N_MAX);
    assign w_inicio = (estado == 3'(INICIO));
    assign w_contar = (estado == 3'(CONTAR));
    assign w_parado = (estado == 3'(PAUSAR)) || (estado == 3'(PARAR));
    assign w_grava  = w_p_volta && w_contar && !w_cheio && !w_inicio;
    assign w_rev_ok = w_p_revisar && w_parado;
    assign w_ultimo = r_num - 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_modo   <= AO_VIVO;
            r_timer  <= '0;
            r_indice <= '0;
            r_num    <= '0;
        end else begin
            r_modo   <= w_modo_n;
            r_timer  <= w_timer_n;
            r_indice <= w_indice_n;
            r_num    <= w_num_n;
        end
    end

    always_comb begin
        w_modo_n   = r_modo;
        w_timer_n  = r_timer;
        w_indice_n = r_indice;
        w_num_n    = r_num;
        if (w_inicio) begin
            w_modo_n   = AO_VIVO;
            w_timer_n  = '0;
            w_indice_n = '0;
            w_num_n    = '0;
        end else if (w_grava) begin
            // A capture wins in every mode, including a fresh reload while frozen
            w_modo_n   = CONGELADO;
            w_timer_n  = T_CARGA;
            w_indice_n = '0;
            w_num_n    = r_num + 1'b1;
        end else begin
            case (r_modo)
                AO_VIVO: begin
                    if (w_rev_ok && (r_num != '0)) begin
                        w_modo_n   = REVISAO;
                        w_indice_n = '0;
                    end
                end
                CONGELADO: begin
                    if (r_timer <= T_UM) begin
                        w_modo_n  = AO_VIVO;
                        w_timer_n = '0;
                    end else begin
                        w_timer_n = r_timer - 1'b1;
                    end
                end
                REVISAO: begin
                    if (w_contar) begin
                        w_modo_n   = AO_VIVO;
                        w_indice_n = '0;
                    end else if (w_rev_ok) begin
                        if ({1'b0, r_indice} == w_ultimo) begin
                            w_modo_n   = AO_VIVO;
                            w_indice_n = '0;
                        end else begin
                            w_indice_n = r_indice + 1'b1;
                        end
                    end
                end
                default: begin
                    w_modo_n   = AO_VIVO;
                    w_indice_n = '0;
                end
            endcase
        end
    end

    logic [13:0] r_mem [MAX_VOLTAS];
    logic [13:0] r_disp;

    always_ff @(posedge clk) begin
        if (w_grava) begin
            r_mem[r_num[IW-1:0]] <= {cont_seg, cont_dec};
        end
    end

    // Display source follows the registered mode, so it lags a mode change by one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_disp <= '0;
        end else begin
            case (r_modo)
                CONGELADO: r_disp <= r_mem[w_ultimo[IW-1:0]];
                REVISAO:   r_disp <= r_mem[r_indice];
                default:   r_disp <= {cont_seg, cont_dec};
            endcase
        end
    end

    assign dec_disp   = r_disp[3:0];
    assign seg_disp   = r_disp[13:4];
    assign modo       = r_modo;
    assign indice     = r_indice;
    assign num_voltas = r_num;
    assign cheio      = w_cheio;

endmodule

// File: tb/tb_seletor_voltas.sv
// Directed bench for seletor_voltas with short debounce and freeze times.
module tb_seletor_voltas;

    logic       clk;
    logic       reset;
    logic       volta;
    logic       revisar;
    logic [2:0] estado;
    logic [3:0] cont_dec;
    logic [9:0] cont_seg;
    logic [3:0] dec_disp;
    logic [9:0] seg_disp;
    logic [1:0] modo;
    logic [1:0] indice;
    logic [2:0] num_voltas;
    logic       cheio;

    int n_tests;
    int n_fail;

    seletor_voltas #(
        .MAX_VOLTAS   (4),
        .DEBOUNCE     (4),
        .TEMPO_CONGELA(10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .volta     (volta),
        .revisar   (revisar),
        .estado    (estado),
        .cont_dec  (cont_dec),
        .cont_seg  (cont_seg),
        .dec_disp  (dec_disp),
        .seg_disp  (seg_disp),
        .modo      (modo),
        .indice    (indice),
        .num_voltas(num_voltas),
        .cheio     (cheio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Clean press: 4 cycles high, 4 low; the capture lands on the 7th edge
    task automatic press_volta();
        volta = 1'b1;
        tick(4);
        volta = 1'b0;
        tick(4);
    endtask

    task automatic press_revisar();
        revisar = 1'b1;
        tick(4);
        revisar = 1'b0;
        tick(4);
    endtask

    task automatic clear_laps();
        estado = 3'd0;
        tick(2);
    endtask

    task automatic test_reset();
        tick(3);
        n_tests++; if (modo !== 2'd0) begin n_fail++; $display("FAIL reset_modo: got %0d expected 0", modo); end
        n_tests++; if (num_voltas !== 3'd0) begin n_fail++; $display("FAIL reset_num: got %0d expected 0", num_voltas); end
        n_tests++; if (cheio !== 1'b0) begin n_fail++; $display("FAIL reset_cheio: got %0d expected 0", cheio); end
        n_tests++; if (indice !== 2'd0) begin n_fail++; $display("FAIL reset_indice: got %0d expected 0", indice); end
        n_tests++; if ({seg_disp, dec_disp} !== 14'd0) begin n_fail++; $display("FAIL reset_disp: got %0d/%0d expected 0/0", seg_disp, dec_disp); end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_bounce();
        clear_laps();
        estado = 3'd1;
        for (int i = 0; i < 3; i++) begin
            volta = 1'b1;
            tick(2);
            volta = 1'b0;
            tick(2);
            n_tests++; if (num_voltas !== 3'd0) begin n_fail++; $display("FAIL bounce_no_capture: got %0d expected 0", num_voltas); end
        end
        volta = 1'b1;
        tick(6);
        n_tests++; if (num_voltas !== 3'd0) begin n_fail++; $display("FAIL bounce_early: got %0d expected 0", num_voltas); end
        tick(1);
        n_tests++; if (num_voltas !== 3'd1) begin n_fail++; $display("FAIL bounce_capture: got %0d expected 1", num_voltas); end
        volta = 1'b0;
        tick(20);
        n_tests++; if (num_voltas !== 3'd1) begin n_fail++; $display("FAIL bounce_single: got %0d expected 1", num_voltas); end
        n_tests++; if (modo !== 2'd0) begin n_fail++; $display("FAIL bounce_modo: got %0d expected 0", modo); end
    endtask

    task automatic test_capture();
        clear_laps();
        estado   = 3'd1;
        cont_seg = 10'd12;
        cont_dec = 4'd7;
        volta    = 1'b1;
        tick(4);
        volta = 1'b0;
        tick(2);
        n_tests++; if (num_voltas !== 3'd0) begin n_fail++; $display("FAIL cap_before: got %0d expected 0", num_voltas); end
        tick(1);
        n_tests++; if (num_voltas !== 3'd1) begin n_fail++; $display("FAIL cap_num: got %0d expected 1", num_voltas); end
        n_tests++; if (modo !== 2'd1) begin n_fail++; $display("FAIL cap_modo: got %0d expected 1", modo); end
        for (int i = 0; i < 10; i++) begin
            cont_seg = 10'(20 + i);
            cont_dec = 4'(i);
            tick(1);
            n_tests++; if (dec_disp !== 4'd7 || seg_disp !== 10'd12) begin n_fail++; $display("FAIL cap_frozen[%0d]: got %0d/%0d expected 12/7", i, seg_disp, dec_disp); end
            n_tests++; if (modo !== ((i < 9) ? 2'd1 : 2'd0)) begin n_fail++; $display("FAIL cap_hold_modo[%0d]: got %0d expected %0d", i, modo, (i < 9) ? 1 : 0); end
        end
        cont_seg = 10'd321;
        cont_dec = 4'd5;
        tick(1);
        n_tests++; if (dec_disp !== 4'd5 || seg_disp !== 10'd321) begin n_fail++; $display("FAIL cap_live: got %0d/%0d expected 321/5", seg_disp, dec_disp); end
    endtask

    task automatic test_full();
        clear_laps();
        estado = 3'd1;
        for (int p = 0; p < 5; p++) begin
            cont_seg = 10'(100 + p);
            cont_dec = 4'(p);
            press_volta();
            n_tests++; if (num_voltas !== ((p < 4) ? 3'(p + 1) : 3'd4)) begin n_fail++; $display("FAIL full_num[%0d]: got %0d expected %0d", p, num_voltas, (p < 4) ? p + 1 : 4); end
            n_tests++; if (cheio !== (p >= 3)) begin n_fail++; $display("FAIL full_cheio[%0d]: got %0d expected %0d", p, cheio, p >= 3); end
            n_tests++; if (modo !== 2'd1) begin n_fail++; $display("FAIL full_modo[%0d]: got %0d expected 1", p, modo); end
            n_tests++; if (seg_disp !== 10'(100 + ((p < 4) ? p : 3)) || dec_disp !== 4'((p < 4) ? p : 3)) begin n_fail++; $display("FAIL full_disp[%0d]: got %0d/%0d expected %0d/%0d", p, seg_disp, dec_disp, 100 + ((p < 4) ? p : 3), (p < 4) ? p : 3); end
        end
        tick(1);
        n_tests++; if (modo !== 2'd0) begin n_fail++; $display("FAIL full_expire: got %0d expected 0", modo); end
    endtask

    task automatic test_review();
        clear_laps();
        estado = 3'd2;
        press_revisar();
        n_tests++; if (modo !== 2'd0 || indice !== 2'd0) begin n_fail++; $display("FAIL rev_empty: got modo %0d indice %0d expected 0 0", modo, indice); end
        estado = 3'd1;
        for (int p = 0; p < 3; p++) begin
            cont_seg = 10'(200 + 7 * p);
            cont_dec = 4'(p + 2);
            press_volta();
        end
        tick(12);
        estado = 3'd2;
        tick(1);
        press_volta();
        n_tests++; if (num_voltas !== 3'd3 || modo !== 2'd0) begin n_fail++; $display("FAIL rev_volta_paused: got num %0d modo %0d expected 3 0", num_voltas, modo); end
        for (int r = 0; r < 3; r++) begin
            press_revisar();
            n_tests++; if (modo !== 2'd2 || indice !== 2'(r)) begin n_fail++; $display("FAIL rev_step[%0d]: got modo %0d indice %0d expected 2 %0d", r, modo, indice, r); end
            n_tests++; if (seg_disp !== 10'(200 + 7 * r) || dec_disp !== 4'(r + 2)) begin n_fail++; $display("FAIL rev_disp[%0d]: got %0d/%0d expected %0d/%0d", r, seg_disp, dec_disp, 200 + 7 * r, r + 2); end
        end
        cont_seg = 10'd777;
        cont_dec = 4'd9;
        press_revisar();
        n_tests++; if (modo !== 2'd0 || indice !== 2'd0) begin n_fail++; $display("FAIL rev_exit: got modo %0d indice %0d expected 0 0", modo, indice); end
        n_tests++; if (seg_disp !== 10'd777 || dec_disp !== 4'd9) begin n_fail++; $display("FAIL rev_live: got %0d/%0d expected 777/9", seg_disp, dec_disp); end
    endtask

    task automatic test_abort();
        press_revisar();
        n_tests++; if (modo !== 2'd2) begin n_fail++; $display("FAIL abort_enter: got %0d expected 2", modo); end
        estado = 3'd1;
        tick(1);
        n_tests++; if (modo !== 2'd0 || indice !== 2'd0) begin n_fail++; $display("FAIL abort_contar: got modo %0d indice %0d expected 0 0", modo, indice); end
        press_volta();
        n_tests++; if (num_voltas !== 3'd4 || cheio !== 1'b1 || modo !== 2'd1) begin n_fail++; $display("FAIL abort_capture: got num %0d cheio %0d modo %0d expected 4 1 1", num_voltas, cheio, modo); end
        estado = 3'd0;
        tick(1);
        n_tests++; if (num_voltas !== 3'd0 || cheio !== 1'b0 || modo !== 2'd0) begin n_fail++; $display("FAIL abort_inicio: got num %0d cheio %0d modo %0d expected 0 0 0", num_voltas, cheio, modo); end
    endtask

    task automatic test_async_reset();
        clear_laps();
        estado   = 3'd1;
        cont_seg = 10'd30;
        cont_dec = 4'd1;
        press_volta();
        n_tests++; if (modo !== 2'd1 || num_voltas !== 3'd1) begin n_fail++; $display("FAIL areset_pre: got modo %0d num %0d expected 1 1", modo, num_voltas); end
        #3;
        reset = 1'b1;
        #1;
        n_tests++; if (modo !== 2'd0 || num_voltas !== 3'd0 || cheio !== 1'b0) begin n_fail++; $display("FAIL areset_ctrl: got modo %0d num %0d cheio %0d expected 0 0 0", modo, num_voltas, cheio); end
        n_tests++; if (seg_disp !== 10'd0 || dec_disp !== 4'd0) begin n_fail++; $display("FAIL areset_disp: got %0d/%0d expected 0/0", seg_disp, dec_disp); end
        #2;
        reset = 1'b0;
        tick(2);
        cont_seg = 10'd555;
        cont_dec = 4'd8;
        press_volta();
        n_tests++; if (num_voltas !== 3'd1 || modo !== 2'd1) begin n_fail++; $display("FAIL areset_post: got num %0d modo %0d expected 1 1", num_voltas, modo); end
        n_tests++; if (seg_disp !== 10'd555 || dec_disp !== 4'd8) begin n_fail++; $display("FAIL areset_slot0: got %0d/%0d expected 555/8", seg_disp, dec_disp); end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b1;
        volta    = 1'b0;
        revisar  = 1'b0;
        estado   = 3'd0;
        cont_dec = 4'd0;
        cont_seg = 10'd0;
        test_reset();
        test_bounce();
        test_capture();
        test_full();
        test_review();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seletor_voltas.md
Name: seletor_voltas

Overview:
Lap-time controller between the stopwatch counter (tenths + seconds) and the seven-segment decoder. Debounces the raw lap and review buttons and captures lap values into a small buffer while counting. Sequences which value is displayed: live count, frozen lap, or lap recall. Reads the stopwatch state FSM code but never drives it.

Parameters:
MAX_VOLTAS, 4, lap buffer depth (power of 2, ≥2)
DEBOUNCE, 500000, cycles a raw button must be stable before its level is accepted (10 ms at 50 MHz)
TEMPO_CONGELA, 100000000, cycles a captured lap stays on the display (2 s)
INICIO, 0, state code: reset/idle
CONTAR, 1, state code: counting
PAUSAR, 2, state code: paused
PARAR, 3, state code: stopped

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
volta  in  1  raw lap button, active-high, asynchronous to clk
revisar  in  1  raw review button, active-high, asynchronous to clk
estado  in  3  current stopwatch FSM state code
cont_dec  in  4  live tenths, 0..9
cont_seg  in  10  live seconds, 0..999
dec_disp  out  4  tenths to seven-segment decoder
seg_disp  out  10  seconds to seven-segment decoder
modo  out  2  0=AO_VIVO, 1=CONGELADO, 2=REVISAO
indice  out  clog2(MAX_VOLTAS)  slot shown in REVISAO; 0 otherwise
num_voltas  out  clog2(MAX_VOLTAS)+1  laps stored
cheio  out  1  num_voltas == MAX_VOLTAS

Behaviour:
- Reset (async): all outputs 0, modo=AO_VIVO, debounce counters/levels 0, hold timer 0, buffer contents don't-care.
- Per button: 2-flop synchronizer. The debounced level updates only after the synchronized input differs from it for DEBOUNCE consecutive cycles. Any bounce restarts the count. A rising edge of the debounced level gives a 1-cycle pulse (p_volta, p_revisar) on the following cycle.
- Lap capture, on p_volta while estado==CONTAR and !cheio:
  - Write {cont_seg,cont_dec} sampled that cycle to slot num_voltas.
  - num_voltas++.
  - Enter CONGELADO, load hold timer with TEMPO_CONGELA.
- p_volta when cheio, or when estado!=CONTAR: ignored, no state change.
- FSM:
  - AO_VIVO: display registered copy of cont_seg/cont_dec (1-cycle latency).
    - Capture → CONGELADO.
    - p_revisar with estado in {PAUSAR,PARAR} and num_voltas>0 → REVISAO, indice=0.
  - CONGELADO: display last captured slot.
    - Timer decrements each cycle; at 0 → AO_VIVO. Frozen display lasts exactly TEMPO_CONGELA cycles.
    - Capture during CONGELADO stores the new lap, shows it, and reloads the timer.
    - p_revisar ignored.
  - REVISAO: display slot indice.
    - p_revisar: if indice==num_voltas-1 → AO_VIVO, indice=0; else indice++.
    - estado==CONTAR → AO_VIVO next cycle; indice=0.
- estado==INICIO, any mode: num_voltas=0, modo=AO_VIVO, timer=0, indice=0 next cycle. Has priority over captures that cycle.
- estado leaving CONTAR during CONGELADO (to PAUSAR/PARAR): timer runs to completion.
- p_volta and p_revisar in the same cycle: at most one is legal for the current estado; evaluate that one only.
- dec_disp/seg_disp are registered and change on the cycle after a modo/indice change.
- No arithmetic on time values; values are copied bit-exact.

Test Plan:
(All with DEBOUNCE=4, TEMPO_CONGELA=10, MAX_VOLTAS=4.)
1. Bounce: volta toggles every 2 cycles for 12 cycles, then held high.
   → Exactly one capture, ≥4+2 cycles after the final rise. No capture during bouncing.
2. Capture/freeze: estado=1, counter at seg=12, dec=7; press volta.
   → num_voltas=1; modo=1; dec_disp=7, seg_disp=12 for 10 cycles while the counter advances; then modo=0 and live value shown.
3. Refreeze/full: 5 presses during CONTAR at distinct values.
   → Captures 1–4 stored, cheio=1 after the 4th; 5th ignored with num_voltas=4. Timer reloads on each of captures 2–4.
4. Review: estado=2 with 3 laps stored; press revisar 4 times.
   → indice 0,1,2 show laps 1..3 in order; 4th press → modo=0.
   - revisar with num_voltas=0 → no change.
5. Abort: estado→1 during REVISAO → modo=0 next cycle. estado→0 during CONGELADO → num_voltas=0, modo=0, cheio=0.
6. Async reset asserted mid-CONGELADO between clock edges.
   → All outputs 0 immediately; after release, a volta press with estado=1 writes slot 0.
